// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_unit and its output buffer.
package fetch_unit_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FULL,
        S_DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// Two-entry {pc, instr} FIFO between imem and the IF/ID register.
// Invalid entries are kept at zero so the head can drive outputs directly.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam fetch_entry_t EMPTY_ENT = '{pc: 32'h0, instr: NOP_INSTR};

    fetch_entry_t ent_q [2];
    logic [1:0]   vld_q;

    // Shift on pop, fill the first free slot on push, clear on flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush) begin
            ent_q[0] <= EMPTY_ENT;
            ent_q[1] <= EMPTY_ENT;
            vld_q    <= 2'b00;
        end else if (pop && push) begin
            if (vld_q[1]) begin
                ent_q[0] <= ent_q[1];
                ent_q[1] <= push_data;
            end else begin
                ent_q[0] <= push_data;
            end
        end else if (pop) begin
            ent_q[0] <= ent_q[1];
            ent_q[1] <= EMPTY_ENT;
            vld_q    <= {1'b0, vld_q[1]};
        end else if (push) begin
            if (!vld_q[0]) begin
                ent_q[0] <= push_data;
                vld_q[0] <= 1'b1;
            end else begin
                ent_q[1] <= push_data;
                vld_q[1] <= 1'b1;
            end
        end
    end

    assign full  = vld_q[1];
    assign empty = ~vld_q[0];
    assign head  = ent_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// buffers two results against stalls and flushes on branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned INSTR_BYTES = fetch_unit_pkg::INSTR_BYTES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    fetch_state_e state_q;
    logic [31:0]  fetch_addr_q;
    logic [31:0]  target_q;

    logic         buf_full;
    logic         buf_empty;
    logic         buf_push;
    logic         buf_pop;
    logic         go_full;
    fetch_entry_t buf_head;
    fetch_entry_t buf_in;

    assign buf_push = (state_q == S_FETCH) & imem_rvalid_i
                    & ~redirect_i & ~buf_full;
    assign buf_pop  = ~buf_empty & ~stall_i;
    assign go_full  = buf_push & ~buf_empty & stall_i;
    assign buf_in   = '{pc: fetch_addr_q, instr: imem_rdata_i};

    fetch_buf u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (redirect_i),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    // Fetch FSM, PC and registered request strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            target_q     <= RESET_PC;
            imem_req_o   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (redirect_i) fetch_addr_q <= redirect_pc_i;
                    state_q    <= S_FETCH;
                    imem_req_o <= 1'b1;
                end
                S_FETCH: begin
                    if (redirect_i) begin
                        if (imem_rvalid_i) begin
                            fetch_addr_q <= redirect_pc_i;
                        end else begin
                            target_q <= redirect_pc_i;
                            state_q  <= S_DISCARD;
                        end
                    end else if (imem_rvalid_i) begin
                        fetch_addr_q <= fetch_addr_q + 32'(INSTR_BYTES);
                        if (go_full) begin
                            state_q    <= S_FULL;
                            imem_req_o <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (redirect_i) begin
                        fetch_addr_q <= redirect_pc_i;
                        state_q      <= S_FETCH;
                        imem_req_o   <= 1'b1;
                    end else if (!stall_i) begin
                        state_q    <= S_FETCH;
                        imem_req_o <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid_i) begin
                        fetch_addr_q <= redirect_i ? redirect_pc_i : target_q;
                        state_q      <= S_FETCH;
                    end else if (redirect_i) begin
                        target_q <= redirect_pc_i;
                    end
                end
            endcase
        end
    end

    assign imem_addr_o = fetch_addr_q;
    assign pc_o        = buf_head.pc;
    assign instr_o     = buf_head.instr;
    assign valid_o     = ~buf_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order scoreboard of
// expected {pc, instr} pairs.
module tb_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    int          checks;
    int          failures;
    logic [63:0] sb[$];
    logic [31:0] exp_addr;
    logic [31:0] held_pc;
    logic [31:0] old_addr;
    bit          discarding;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .INSTR_BYTES (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .valid_o       (valid_o)
    );

    assign imem_rdata_i = imem_addr_o ^ 32'hA5A5_0000;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_out(input string tag);
        chk({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
        chk({tag, "_pc"}, pc_o, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
    endtask

    // Memory handshake and consumer side, then advance one clock.
    task automatic cyc();
        logic [63:0] e;
        if (rst_i && imem_req_o && imem_rvalid_i && !redirect_i
            && !discarding) begin
            chk("imem_addr", imem_addr_o, exp_addr);
            sb.push_back({exp_addr, exp_addr ^ 32'hA5A5_0000});
            exp_addr += 32'd4;
        end
        if (rst_i && valid_o && !stall_i && !redirect_i) begin
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc_o", pc_o, e[63:32]);
                chk("instr_o", instr_o, e[31:0]);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        exp_addr      = 32'h0;
        discarding    = 1'b0;
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 3; i++) begin
            chk_zero_out("rst");
            chk("rst_req", {31'b0, imem_req_o}, 32'd0);
            cyc();
        end

        rst_i = 1'b1;
        chk("rel_req0", {31'b0, imem_req_o}, 32'd0);
        cyc();
        chk("first_req", {31'b0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        chk_zero_out("first");

        imem_rvalid_i = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", {31'b0, valid_o}, 32'd1);
            cyc();
        end

        held_pc = sb[0][63:32];
        stall_i = 1'b1;
        chk("stall_pc", pc_o, held_pc);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", pc_o, held_pc);
            chk("stall_valid", {31'b0, valid_o}, 32'd1);
            chk("stall_req", {31'b0, imem_req_o}, 32'd0);
            cyc();
        end
        stall_i = 1'b0;
        chk("stall_pc", pc_o, held_pc);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("resume_valid", {31'b0, valid_o}, 32'd1);
            chk("resume_req", {31'b0, imem_req_o}, 32'd1);
            cyc();
        end

        imem_rvalid_i = 1'b0;
        stall_i       = 1'b1;
        cyc();
        old_addr = exp_addr;
        chk("wait_valid", {31'b0, valid_o}, 32'd1);
        chk("wait_addr", imem_addr_o, old_addr);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        cyc();
        sb.delete();
        discarding = 1'b1;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        chk_zero_out("redir");
        chk("disc_addr", imem_addr_o, old_addr);
        chk("disc_req", {31'b0, imem_req_o}, 32'd1);
        cyc();
        chk("disc_addr2", imem_addr_o, old_addr);
        chk("disc_valid2", {31'b0, valid_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        cyc();
        discarding = 1'b0;
        exp_addr   = 32'h100;
        chk("drop_valid", {31'b0, valid_o}, 32'd0);
        chk("target_addr", imem_addr_o, 32'h100);
        cyc();
        chk("redir_valid", {31'b0, valid_o}, 32'd1);
        chk("redir_pc", pc_o, 32'h100);
        cyc();
        cyc();

        redirect_i    = 1'b1;
        stall_i       = 1'b1;
        redirect_pc_i = 32'h200;
        chk("rs_valid_pre", {31'b0, valid_o}, 32'd1);
        cyc();
        sb.delete();
        exp_addr   = 32'h200;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        chk_zero_out("redir_stall");
        chk("rs_addr", imem_addr_o, 32'h200);
        cyc();
        chk("rs_pc", pc_o, 32'h200);
        cyc();
        cyc();

        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        cyc();
        sb.delete();
        discarding = 1'b1;
        redirect_i = 1'b0;
        chk("d2_addr", imem_addr_o, exp_addr);
        chk("d2_req", {31'b0, imem_req_o}, 32'd1);
        rst_i = 1'b0;
        cyc();
        chk_zero_out("rst2");
        chk("rst2_req", {31'b0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        cyc();
        chk_zero_out("rst2b");
        rst_i      = 1'b1;
        discarding = 1'b0;
        exp_addr   = 32'h0;
        cyc();
        chk("late_valid", {31'b0, valid_o}, 32'd0);
        chk("rst2_req1", {31'b0, imem_req_o}, 32'd1);
        chk("rst2_addr", imem_addr_o, 32'h0);
        cyc();
        chk("rst2_pc", pc_o, 32'h0);
        chk("rst2_vld", {31'b0, valid_o}, 32'd1);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch producer stage that drives the IF/ID pipeline register with pc_o, instr_o and valid_o.
- Owns the PC. Issues one outstanding request at a time to a variable-latency instruction memory.
- Absorbs downstream stalls with a 2-entry output buffer. Flushes and redirects on branch-taken.
- Sits between imem and IF/ID. stall_i comes from the hazard unit; redirect_i comes from the branch logic in ID.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- INSTR_BYTES, 4, PC increment per sequential fetch.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset. Synchronous, active-low.
- imem_req_o  out  1  fetch request; held until imem_rvalid_i.
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1.
- imem_rvalid_i  in  1  data valid. Completes the outstanding request; may occur in the same cycle as the request.
- imem_rdata_i  in  32  instruction word, valid with imem_rvalid_i.
- stall_i  in  1  downstream hold (IF/ID not written this cycle).
- redirect_i  in  1  branch taken; flush and refetch from redirect_pc_i.
- redirect_pc_i  in  32  redirect target, sampled when redirect_i=1.
- pc_o  out  32  PC of presented instruction; 0 when valid_o=0.
- instr_o  out  32  presented instruction; 0 (bubble) when valid_o=0.
- valid_o  out  1  pc_o/instr_o hold a real instruction.

Behaviour:
- Reset: rst_i=0 at a posedge sets the following.
  - state=S_IDLE, fetch_addr=RESET_PC.
  - Both buffer entries invalid.
  - pc_o=0, instr_o=0, valid_o=0.
  - imem_req_o=0 while in S_IDLE.
- Reset applied in any state, including mid-request, wins over all other inputs. Any late imem_rvalid_i is ignored while in S_IDLE.
- States and transitions:
  - S_IDLE: req=0. Next cycle goes to S_FETCH. The first request is therefore asserted in the 2nd cycle after rst_i rises.
  - S_FETCH: req=1, addr=fetch_addr. On rvalid with no redirect:
    - Write {fetch_addr, rdata} into the buffer and set fetch_addr += INSTR_BYTES.
    - If the buffer is then full (2 entries) with the head stalled, go to S_FULL; else stay in S_FETCH.
  - S_FULL: req=0. When stall_i=0 the head is consumed and the tail moves up; return to S_FETCH.
  - S_DISCARD: req=1 with the old address.
    - On rvalid: drop the data, fetch_addr=target_q, go to S_FETCH.
    - A redirect while in S_DISCARD overwrites target_q (latest target wins).
- Buffer rules:
  - The head entry drives pc_o/instr_o/valid_o directly from registers.
  - Consume = valid_o & ~stall_i; the head advances at the next edge.
  - Fetch latency is 1 cycle: rvalid at edge N gives valid_o=1 after edge N when the buffer was empty.
  - No gap or duplicate when consume and rvalid happen in the same cycle.
- Redirect (redirect_i=1) has highest priority after reset:
  - Both buffer entries are invalidated next cycle (pc_o=0, instr_o=0, valid_o=0), regardless of stall_i.
  - In S_FETCH, if rvalid occurs in the same cycle: drop the data, fetch_addr=redirect_pc_i, stay in S_FETCH.
  - In S_FETCH without rvalid: target_q=redirect_pc_i, go to S_DISCARD.
  - In S_IDLE or S_FULL: fetch_addr=redirect_pc_i, go to S_FETCH.
- Arithmetic: fetch_addr wraps modulo 2^32. redirect_pc_i is used unchanged (no alignment check).
- imem_rvalid_i while req=0 is a protocol error; the data is ignored.

Decomposition:
- Shared package holds:
  - State enum S_IDLE/S_FETCH/S_FULL/S_DISCARD.
  - NOP_INSTR=32'h0 (also the IF/ID flush value).
  - INSTR_BYTES.
- One sub-module: fetch_buf, a 2-entry FIFO of {pc, instr} with push, pop, flush, full/empty and head outputs.
- FSM and PC logic stay in fetch_unit.

Test Plan:
- Hold rst_i=0 for 3 cycles, then release:
  - During reset, all outputs are 0 and req=0.
  - req=1 with addr=0 in the 2nd cycle after release.
- rvalid tied 1, rdata=addr^32'hA5A5_0000, no stall:
  - pc_o=0,4,8,12 on consecutive cycles with valid_o=1 continuously.
  - instr_o matches the rdata for each address.
- Stall_i=1 for 4 cycles during streaming:
  - pc_o holds its value.
  - One extra entry is buffered, then req=0 (S_FULL).
  - After release, pc_o advances by 4 every cycle with no repeat or skip.
- rvalid delayed 3 cycles, redirect_i=1 with redirect_pc_i=0x100 during the wait:
  - valid_o=0 next cycle.
  - addr stays at the old value until rvalid; that data is dropped.
  - Next addr=0x100, then pc_o=0x100.
- Redirect_i and stall_i both 1 with valid_o=1: next cycle valid_o=0, pc_o=0, instr_o=0.
- rst_i=0 asserted while in S_DISCARD:
  - Outputs are 0; a late rvalid is ignored.
  - After release, the first addr is RESET_PC.
